// File: rtl/crc_serial_engine.sv
// ---------------------------------------------------------------------------
// crc_serial_engine
//   Bit-serial, non-reflected CRC engine. It accepts parallel words over a
//   valid/ready handshake and folds each one into a running CRC, MSB first,
//   one bit per clock. When the word tagged 'last' has been folded in, the
//   final CRC (crc ^ XOR_OUT) is presented on o_crc_out with a one-cycle
//   o_crc_valid pulse, and the CRC is reseeded with INIT.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a word; i_start reloads the CRC with INIT
//   S_SHIFT | folding the held word into the CRC, one bit per clock
//   S_DONE  | result on o_crc_out, o_crc_valid high, CRC reseeded
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_start       reload CRC with INIT (honoured in S_IDLE only)
//   i_data_in     word to fold in, bit DATA_W-1 first
//   i_data_valid  i_data_in / i_data_last are valid
//   i_data_last   this word ends the message
//   o_data_ready  engine accepts a word this cycle
//   o_busy        shifting a word or presenting a result
//   o_crc_out     final CRC, held until the next result
//   o_crc_valid   one-cycle pulse when o_crc_out updates
// ---------------------------------------------------------------------------
module crc_serial_engine #(
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 'h07,
    parameter logic [CRC_W-1:0] INIT    = 'h00,
    parameter logic [CRC_W-1:0] XOR_OUT = 'h00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_data_valid,
    input  logic              i_data_last,
    output logic              o_data_ready,
    output logic              o_busy,
    output logic [CRC_W-1:0]  o_crc_out,
    output logic              o_crc_valid
);

    localparam int unsigned      CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CRC_W-1:0]   r_crc;
    logic [DATA_W-1:0]  r_shreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_last_q;
    logic [CRC_W-1:0]   r_crc_out;
    logic               r_crc_valid;

    logic               w_ready;
    logic               w_transfer;
    logic               w_bit_last;
    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_nxt;

    // One LFSR step: feedback is the outgoing CRC MSB XOR the incoming data bit.
    assign w_fb      = r_crc[CRC_W-1] ^ r_shreg[DATA_W-1];
    assign w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    assign w_bit_last = (r_bitcnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (i_data_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bit_last) begin
                    w_state_nxt = r_last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_transfer = w_ready & i_data_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc       <= INIT;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_last_q    <= 1'b0;
            r_crc_out   <= '0;
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with a transfer seeds the word's fold.
                    if (i_start) begin
                        r_crc <= INIT;
                    end
                    if (w_transfer) begin
                        r_shreg  <= i_data_in;
                        r_last_q <= i_data_last;
                        r_bitcnt <= L_CNT_LAST;
                    end
                end
                S_SHIFT: begin
                    r_crc    <= w_crc_nxt;
                    r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 1'b1;
                    if (w_bit_last && r_last_q) begin
                        r_crc_out   <= w_crc_nxt ^ XOR_OUT;
                        r_crc_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Auto-reseed so the next message needs no start pulse.
                    r_crc <= INIT;
                end
                default: begin
                    r_crc <= INIT;
                end
            endcase
        end
    end

    assign o_data_ready = w_ready;
    assign o_busy       = ~w_ready;
    assign o_crc_out    = r_crc_out;
    assign o_crc_valid  = r_crc_valid;

endmodule

// File: tb/tb_crc_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_serial_engine
//   Scoreboard bench for crc_serial_engine with CRC-8 defaults
//   (POLY=07, INIT=00, XOR_OUT=00). Each message's expected CRC and the cycle
//   its crc_valid pulse is due are queued when the last word transfers; a
//   monitor pops and checks them whenever crc_valid is seen.
// ---------------------------------------------------------------------------
module tb_crc_serial_engine;

    localparam int DATA_W = 8;
    localparam int CRC_W  = 8;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0] crc;
        int         due;
    } exp_t;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic [DATA_W-1:0] i_data_in;
    logic              i_data_valid;
    logic              i_data_last;
    logic              o_data_ready;
    logic              o_busy;
    logic [CRC_W-1:0]  o_crc_out;
    logic              o_crc_valid;

    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    exp_t   exp_q[$];
    logic   prev_valid = 1'b0;

    byte_q_t s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc_serial_engine #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (8'h07),
        .INIT   (8'h00),
        .XOR_OUT(8'h00)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_data_in   (i_data_in),
        .i_data_valid(i_data_valid),
        .i_data_last (i_data_last),
        .o_data_ready(o_data_ready),
        .o_busy      (o_busy),
        .o_crc_out   (o_crc_out),
        .o_crc_valid (o_crc_valid)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-wise reference CRC-8 (poly 07, init 00, no final XOR).
    function automatic logic [7:0] ref_crc(input byte_q_t msg);
        logic [7:0] c;
        c = 8'h00;
        foreach (msg[i]) begin
            c = c ^ msg[i];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge i_clk) begin
        exp_t e;
        if (prev_valid) begin
            n_assert++;
            if (o_crc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL crc_valid_width: crc_valid=%b at cycle %0d, required 0 (one-cycle pulse)", o_crc_valid, cyc);
            end
        end
        if (o_crc_valid === 1'b1 && !prev_valid) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_crc_valid: crc_valid=1 at cycle %0d with crc_out=%h, required no result", cyc, o_crc_out);
            end else begin
                e = exp_q.pop_front();
                if (o_crc_out !== e.crc) begin
                    n_fail++;
                    $display("FAIL crc_value: crc_out=%h, required %h", o_crc_out, e.crc);
                end
                n_assert++;
                if (cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL crc_latency: crc_valid at cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
        end
        prev_valid = (o_crc_valid === 1'b1);
    end

    // Entered and left at posedge+1. Returns with o_data_ready=1 so the next
    // word can transfer on the first IDLE cycle.
    task automatic send_word(input logic [7:0] d, input logic last, input logic start_with,
                             input logic gaps, input logic start_mid, input logic [7:0] exp_crc,
                             output int lowcnt);
        int n;
        int k;
        if (gaps) begin
            i_data_valid = 1'b0;
            i_data_in    = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_clk); #1;
            end
        end
        i_data_in    = d;
        i_data_last  = last;
        i_data_valid = 1'b1;
        i_start      = start_with;
        n = 0;
        while (o_data_ready !== 1'b1 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (o_data_ready !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL ready_timeout: data_ready=%b after %0d cycles, required 1", o_data_ready, n);
        end
        @(posedge i_clk); #1;
        k = cyc;
        i_start = 1'b0;
        if (last) exp_q.push_back('{exp_crc, k + DATA_W});
        lowcnt = 0;
        while (o_data_ready !== 1'b1 && lowcnt < 100) begin
            lowcnt++;
            i_start = (start_mid && lowcnt == 4);
            if (gaps) begin
                i_data_valid = 1'($urandom_range(0, 1));
                i_data_in    = 8'($urandom);
                i_data_last  = 1'($urandom_range(0, 1));
            end
            @(posedge i_clk); #1;
        end
        i_start = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input logic with_last, input logic start_first,
                            input logic start_mid, input logic gaps, input logic check_low);
        int         low;
        logic [7:0] exp_crc;
        logic       is_last;
        exp_crc = ref_crc(msg);
        for (int i = 0; i < msg.size(); i++) begin
            is_last = with_last && (i == msg.size() - 1);
            send_word(msg[i], is_last, start_first && i == 0, gaps, start_mid && i == 1, exp_crc, low);
            if (check_low) begin
                n_assert++;
                if (low !== (is_last ? DATA_W + 1 : DATA_W)) begin
                    n_fail++;
                    $display("FAIL ready_low_cycles: word %0d ready low %0d cycles, required %0d",
                             i, low, is_last ? DATA_W + 1 : DATA_W);
                end
            end
        end
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_assert++;
        if (o_data_ready !== 1'b1 || o_busy !== 1'b0 || o_crc_valid !== 1'b0 || o_crc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: ready=%b busy=%b crc_valid=%b crc_out=%h, required ready=1 busy=0 crc_valid=0 crc_out=00",
                     tag, o_data_ready, o_busy, o_crc_valid, o_crc_out);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_data_in = 8'h00;
        i_data_valid = 1'b0;
        i_data_last = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset_state");
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_single_words();
        int low;
        send_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, low);
        n_assert++;
        if (low !== DATA_W + 1) begin
            n_fail++;
            $display("FAIL last_word_ready_low: %0d cycles, required %0d", low, DATA_W + 1);
        end
        send_word(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF3, low);
        send_word(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, low);
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
    endtask

    task automatic test_check_string();
        n_assert++;
        if (ref_crc(s9) !== 8'hF4) begin
            n_fail++;
            $display("FAIL model_check_value: model gives %h, required F4", ref_crc(s9));
        end
        send_msg(s9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        int low;
        send_word(8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, low);
        i_data_in    = 8'h32;
        i_data_last  = 1'b1;
        i_data_valid = 1'b1;
        @(posedge i_clk); #1;
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        repeat (4) begin
            @(posedge i_clk); #1;
        end
        n_assert++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_word: busy=%b, required 1", o_busy);
        end
        #1 i_rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_word");
        @(posedge i_clk); #1;
        check_reset_outputs("reset_held");
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        send_msg(s9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start();
        byte_q_t part = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_msg(part, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_msg(s9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_msg(s9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random_gaps();
        send_msg(s9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_msg(s9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_drain();
        repeat (20) @(posedge i_clk);
        #1;
        n_assert++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL missing_results: %0d expected results never produced, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_words();
        test_check_string();
        test_reset_mid_word();
        test_start();
        test_random_gaps();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
